fifo_thr: RTL

- Parametrised successor to the basic NORA byte FIFO.
- Adds the following to the fixed-function FIFO:
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a synchronous flush;
  - defined behaviour for enqueue and dequeue in the same cycle at full and at empty.
- Used between the SPI/UART front ends and the bus-side register interface, where the firmware polls threshold flags instead of exact counts.

---
 rtl/fifo_thr_flags.sv | 36 +++
 rtl/fifo_thr.sv | 99 +++++++++
 2 files changed

// File: rtl/fifo_thr_flags.sv
// Registered full/empty/almost flags computed from the next-cycle element count.
// Flags change on the same edge as the count they describe; no backpressure of its own.
module fifo_thr_flags #(
  parameter int BITDEPTH   = 2,
  parameter int AFULL_THR  = (1 << BITDEPTH) - 1,
  parameter int AEMPTY_THR = 1
) (
  input  logic              clk6x,
  input  logic              resetn,
  input  logic [BITDEPTH:0] cnt_nxt,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty
);

  localparam int DEPTH = 1 << BITDEPTH;
  localparam logic [BITDEPTH:0] FULL_CNT   = (BITDEPTH+1)'(DEPTH);
  localparam logic [BITDEPTH:0] AFULL_CNT  = (BITDEPTH+1)'(AFULL_THR);
  localparam logic [BITDEPTH:0] AEMPTY_CNT = (BITDEPTH+1)'(AEMPTY_THR);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      full   <= (cnt_nxt == FULL_CNT);
      empty  <= (cnt_nxt == '0);
      afull  <= (cnt_nxt >= AFULL_CNT);
      aempty <= (cnt_nxt <= AEMPTY_CNT);
    end
  end

endmodule

// File: rtl/fifo_thr.sv
// First-word-fall-through FIFO with programmable almost-full/empty flags, sticky errors and flush.
// Head visible the cycle after enqueue; writes at full without a read are dropped and flagged.
module fifo_thr #(
  parameter int BITWIDTH   = 8,
  parameter int BITDEPTH   = 2,
  parameter int AFULL_THR  = (1 << BITDEPTH) - 1,
  parameter int AEMPTY_THR = 1
) (
  input  logic                clk6x,
  input  logic                resetn,
  input  logic                flush_i,
  input  logic [BITWIDTH-1:0] wport_i,
  input  logic                wenq_i,
  output logic [BITWIDTH-1:0] rport_o,
  input  logic                rdeq_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                afull_o,
  output logic                aempty_o,
  output logic [BITDEPTH:0]   count_o,
  output logic                ovf_o,
  output logic                unf_o,
  input  logic                clrerr_i
);

  localparam int DEPTH = 1 << BITDEPTH;
  localparam logic [BITDEPTH-1:0] PTR_ONE = BITDEPTH'(1);
  localparam logic [BITDEPTH:0]   CNT_ONE = (BITDEPTH+1)'(1);

  logic [BITWIDTH-1:0] mem [DEPTH];
  logic [BITDEPTH-1:0] wptr, rptr;
  logic [BITDEPTH:0]   cnt, cnt_nxt;
  logic                do_wr, do_rd, ovf_evt, unf_evt;

  // A read at full frees the slot the simultaneous write needs.
  assign do_wr   = !flush_i && wenq_i && (!full_o || rdeq_i);
  assign do_rd   = !flush_i && rdeq_i && !empty_o;
  assign ovf_evt = !flush_i && wenq_i && full_o && !rdeq_i;
  assign unf_evt = !flush_i && rdeq_i && empty_o;

  always_comb begin
    cnt_nxt = cnt;
    if (flush_i)
      cnt_nxt = '0;
    else if (do_wr && !do_rd)
      cnt_nxt = cnt + CNT_ONE;
    else if (do_rd && !do_wr)
      cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk6x) begin
    if (do_wr) mem[wptr] <= wport_i;
  end

  // A new error event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      ovf_o <= ovf_evt || (ovf_o && !clrerr_i);
      unf_o <= unf_evt || (unf_o && !clrerr_i);
    end
  end

  fifo_thr_flags #(
    .BITDEPTH   (BITDEPTH),
    .AFULL_THR  (AFULL_THR),
    .AEMPTY_THR (AEMPTY_THR)
  ) u_flags (
    .clk6x   (clk6x),
    .resetn  (resetn),
    .cnt_nxt (cnt_nxt),
    .full    (full_o),
    .empty   (empty_o),
    .afull   (afull_o),
    .aempty  (aempty_o)
  );

  assign rport_o = mem[rptr];
  assign count_o = cnt;

endmodule
